lsu_mc: RTL and testbench
=========================

Name: lsu_mc

Overview:
- Multi-cycle, parametrised load/store unit between the EXU/LSU pipeline stage and the data-memory bus.
- Replaces the single-cycle combinational DPI access with valid/ready handshakes on three sides: upstream request, memory request/response, and upstream result.
- Supports XLEN 32 or 64, byte-lane alignment of write data and strobes, load extraction with sign/zero extension, and error reporting.

Parameters:
- XLEN, 32, data and address width; legal values are 32 and 64.
- STRB_W, XLEN/8, write-strobe width; derived, never overridden.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. The name is kept per codebase convention, but the reset is synchronous and active-high.
- in_valid  in  1  request valid.
- in_ready  out  1  request accept; high only in IDLE.
- in_is_store  in  1  1 = store, 0 = load.
- in_funct3  in  3  RISC-V load/store funct3.
- in_addr  in  XLEN  byte address.
- in_wdata  in  XLEN  store data, right-aligned.
- out_valid  out  1  result valid.
- out_ready  in  1  result accept.
- out_rdata  out  XLEN  extended load data; 0 for stores and errors.
- out_err  out  1  access fault, illegal funct3, or misaligned access.
- mem_req_valid  out  1  bus request valid.
- mem_req_ready  in  1  bus request accept.
- mem_req_addr  out  XLEN  word-aligned address (low log2(STRB_W) bits = 0).
- mem_req_wen  out  1  write request.
- mem_req_wdata  out  XLEN  lane-shifted write data.
- mem_req_wstrb  out  STRB_W  byte strobes; all 0 for reads.
- mem_rsp_valid  in  1  response valid.
- mem_rsp_ready  out  1  response accept; high only in RESP.
- mem_rsp_rdata  in  XLEN  read word.
- mem_rsp_err  in  1  bus fault.

Behaviour:
- Reset: state = IDLE. in_ready=0 while rst_n is high. out_valid=0, out_err=0, out_rdata=0, mem_req_valid=0, mem_req_wen=0, mem_req_wstrb=0, mem_rsp_ready=0.
- FSM IDLE -> REQ -> RESP -> DONE -> IDLE. All mem_req_* and out_* outputs are registered.
- IDLE: on in_valid && in_ready, capture funct3, is_store, addr, and wdata.
  - Legal access: go to REQ.
  - Illegal or (with the feature) misaligned access: go to DONE with out_err=1.
- REQ: mem_req_valid=1. Address, wen, wdata, and wstrb are held stable until mem_req_ready. On the handshake, go to RESP.
- RESP: mem_rsp_ready=1. On mem_rsp_valid, latch the result and go to DONE.
  - mem_rsp_err=1 -> out_err=1, out_rdata=0.
  - A response arriving in the same cycle the state enters RESP is not possible: a response is only taken while in RESP.
- DONE: out_valid=1, with out_rdata and out_err stable, until out_ready. Then go to IDLE; a new request is accepted the next cycle.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, out_valid at N+3 (zero-wait bus).
- Size: funct3[1:0] gives 1/2/4/8 bytes. off = addr[log2(STRB_W)-1:0].
  - mem_req_wstrb = size-mask << off, truncated to STRB_W.
  - mem_req_wdata = in_wdata << 8*off.
- Load data: sh = mem_rsp_rdata >> 8*off.
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: sign-extend word when XLEN=64; full word when XLEN=32.
  - 011 LD: XLEN=64 only.
  - 100 LBU, 101 LHU: zero-extend.
  - 110 LWU: XLEN=64 only, zero-extend.
- Illegal funct3: out_err=1, no bus access, out_rdata=0.
  - XLEN=32: 011, 110, 111.
  - Stores: any funct3 with funct3[2]=1.
- Stores return out_rdata=0.
- Without the feature, a misaligned access that crosses the word boundary loses the overflow bytes:
  - store strobes are truncated;
  - load bytes beyond the word read as 0 before extension.
- Reset in any state: return to IDLE and abandon the transaction. The bus is reset by the same signal. Responses while not in RESP are ignored because mem_rsp_ready=0.

Optional Feature:
- LSU_MISALIGN_CHK_EN.
- Defined: an access is misaligned when addr mod size != 0. A misaligned access produces no bus request, out_err=1, and out_valid one cycle after accept (IDLE -> DONE).
- Undefined: no check; the truncation rules above apply.

Test Plan:
- XLEN=32, LB addr 0x80000003, mem_rsp_rdata 0x80FF1234 -> mem_req_addr 0x80000000, wstrb 0000, out_rdata 0xFFFFFF80, out_err 0, out_valid 3 cycles after accept.
- SH addr 0x80000002, in_wdata 0x0000ABCD -> mem_req_wdata 0xABCD0000, wstrb 1100, mem_req_wen 1, out_rdata 0.
- LHU addr 0x80000000; mem_req_ready low 5 cycles, then mem_rsp_err=1 -> request fields stable for all 5 cycles, in_ready 0, out_err 1, out_rdata 0.
- LW addr 0x80000001 with LSU_MISALIGN_CHK_EN -> no mem_req_valid, out_valid the next cycle, out_err 1. Without it, rdata 0x11223344 -> out_rdata 0x00112233.
- out_ready held low 3 cycles -> out_valid and out_rdata stable; a new in_valid is accepted the cycle after the out handshake.
- Reset asserted in RESP; a late mem_rsp_valid follows -> outputs at reset values, response ignored. XLEN=64 LWU addr 0x4 with rdata 0xF0000000_00000000 -> out_rdata 0x00000000F0000000.

Source files
------------

// File: rtl/lsu_mc.sv
// lsu_mc: multi-cycle load/store unit with valid/ready handshakes toward the pipeline and data bus.
// Define LSU_MISALIGN_CHK_EN to reject misaligned accesses locally instead of truncating them.
module lsu_mc #(
  parameter int unsigned  XLEN   = 32,
  localparam int unsigned STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rdata,
  output logic              out_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic              mem_req_wen,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [STRB_W-1:0] mem_req_wstrb,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  input  logic              mem_rsp_err
);
  localparam int unsigned OffW = $clog2(STRB_W);

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              is_store_q, is_store_d;
  logic [OffW-1:0]   off_q, off_d;
  logic              mem_req_valid_q, mem_req_valid_d;
  logic [XLEN-1:0]   mem_req_addr_q, mem_req_addr_d;
  logic              mem_req_wen_q, mem_req_wen_d;
  logic [XLEN-1:0]   mem_req_wdata_q, mem_req_wdata_d;
  logic [STRB_W-1:0] mem_req_wstrb_q, mem_req_wstrb_d;
  logic              mem_rsp_ready_q, mem_rsp_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
  logic              out_err_q, out_err_d;

  logic [OffW-1:0]   in_off;
  logic [7:0]        size_mask;
  logic              illegal;
  logic              misalign;
  logic [XLEN-1:0]   rsp_sh;
  logic [XLEN-1:0]   load_ext;

  assign in_off   = in_addr[OffW-1:0];
  assign in_ready = (state_q == StIdle) && !rst_n;

  always_comb begin
    unique case (in_funct3[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0f;
      default: size_mask = 8'hff;
    endcase
    illegal = (in_funct3 == 3'b111) || (in_is_store && in_funct3[2]);
    if (XLEN == 32) begin
      illegal = illegal || (in_funct3 == 3'b011) || (in_funct3 == 3'b110);
    end
`ifdef LSU_MISALIGN_CHK_EN
    // Low address bits that must be zero for a naturally aligned 1/2/4/8-byte access.
    misalign = |(in_addr[2:0] & {&in_funct3[1:0], in_funct3[1], |in_funct3[1:0]});
`else
    misalign = 1'b0;
`endif
  end

  // Bytes above the word boundary shift in as zero before extension.
  always_comb begin
    rsp_sh = mem_rsp_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  load_ext = XLEN'($signed(rsp_sh[7:0]));
      3'b001:  load_ext = XLEN'($signed(rsp_sh[15:0]));
      3'b010:  load_ext = XLEN'($signed(rsp_sh[31:0]));
      3'b011:  load_ext = rsp_sh;
      3'b100:  load_ext = XLEN'(rsp_sh[7:0]);
      3'b101:  load_ext = XLEN'(rsp_sh[15:0]);
      3'b110:  load_ext = XLEN'(rsp_sh[31:0]);
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    funct3_d        = funct3_q;
    is_store_d      = is_store_q;
    off_d           = off_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    mem_req_wen_d   = mem_req_wen_q;
    mem_req_wdata_d = mem_req_wdata_q;
    mem_req_wstrb_d = mem_req_wstrb_q;
    mem_rsp_ready_d = mem_rsp_ready_q;
    out_valid_d     = out_valid_q;
    out_rdata_d     = out_rdata_q;
    out_err_d       = out_err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          funct3_d   = in_funct3;
          is_store_d = in_is_store;
          off_d      = in_off;
          if (illegal || misalign) begin
            state_d     = StDone;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_rdata_d = '0;
          end else begin
            state_d         = StReq;
            mem_req_valid_d = 1'b1;
            mem_req_addr_d  = {in_addr[XLEN-1:OffW], {OffW{1'b0}}};
            mem_req_wen_d   = in_is_store;
            mem_req_wdata_d = in_is_store ? (in_wdata << {in_off, 3'b000}) : '0;
            mem_req_wstrb_d = in_is_store ? STRB_W'({8'h00, size_mask} << in_off) : '0;
          end
        end
      end
      StReq: begin
        if (mem_req_ready) begin
          state_d         = StResp;
          mem_req_valid_d = 1'b0;
          mem_rsp_ready_d = 1'b1;
        end
      end
      StResp: begin
        if (mem_rsp_valid) begin
          state_d         = StDone;
          mem_rsp_ready_d = 1'b0;
          out_valid_d     = 1'b1;
          out_err_d       = mem_rsp_err;
          out_rdata_d     = (mem_rsp_err || is_store_q) ? '0 : load_ext;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          out_rdata_d = '0;
        end
      end
    endcase
  end

  // rst_n is a synchronous, active-high reset despite its name.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q         <= StIdle;
      funct3_q        <= '0;
      is_store_q      <= 1'b0;
      off_q           <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wen_q   <= 1'b0;
      mem_req_wdata_q <= '0;
      mem_req_wstrb_q <= '0;
      mem_rsp_ready_q <= 1'b0;
      out_valid_q     <= 1'b0;
      out_rdata_q     <= '0;
      out_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      funct3_q        <= funct3_d;
      is_store_q      <= is_store_d;
      off_q           <= off_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      mem_req_wen_q   <= mem_req_wen_d;
      mem_req_wdata_q <= mem_req_wdata_d;
      mem_req_wstrb_q <= mem_req_wstrb_d;
      mem_rsp_ready_q <= mem_rsp_ready_d;
      out_valid_q     <= out_valid_d;
      out_rdata_q     <= out_rdata_d;
      out_err_q       <= out_err_d;
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;
  assign mem_req_wen   = mem_req_wen_q;
  assign mem_req_wdata = mem_req_wdata_q;
  assign mem_req_wstrb = mem_req_wstrb_q;
  assign mem_rsp_ready = mem_rsp_ready_q;
  assign out_valid     = out_valid_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_lsu_mc.sv
// tb_lsu_mc: scoreboard bench for lsu_mc; a 32-bit instance with a stalling bus model and
// a 64-bit instance on a zero-wait bus.
module tb_lsu_mc;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wen;
    logic [3:0]  wstrb;
    int          stall;
    logic [31:0] rdata;
    logic        err;
    bit          hold;
  } req_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          ostall;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];
  exp_t exp64_q[$];

  int tests = 0;
  int fails = 0;
  int last_accept = 0;
  int out_hs_cyc = 0;
  bit force_rsp = 1'b0;

  logic        rst_n;
  logic        in_valid, in_ready, in_is_store;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;
  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_ready, mem_rsp_err;
  logic [31:0] mem_rsp_rdata;

  lsu_mc #(.XLEN(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  logic        w_in_valid, w_in_ready, w_in_is_store;
  logic [2:0]  w_in_funct3;
  logic [63:0] w_in_addr, w_in_wdata, w_out_rdata, rd64;
  logic        w_out_valid, w_out_err, w_mem_req_valid, w_mem_req_wen, w_mem_rsp_ready;
  logic [63:0] w_mem_req_addr, w_mem_req_wdata;
  logic [7:0]  w_mem_req_wstrb;
  wire         w_out_ready = 1'b1;
  wire         w_mem_req_ready = 1'b1;
  wire         w_mem_rsp_valid = w_mem_rsp_ready;
  wire         w_mem_rsp_err = 1'b0;
  wire  [63:0] w_mem_rsp_rdata = rd64;

  lsu_mc #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_is_store(w_in_is_store),
    .in_funct3(w_in_funct3), .in_addr(w_in_addr), .in_wdata(w_in_wdata),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_rdata(w_out_rdata),
    .out_err(w_out_err),
    .mem_req_valid(w_mem_req_valid), .mem_req_ready(w_mem_req_ready),
    .mem_req_addr(w_mem_req_addr), .mem_req_wen(w_mem_req_wen),
    .mem_req_wdata(w_mem_req_wdata), .mem_req_wstrb(w_mem_req_wstrb),
    .mem_rsp_valid(w_mem_rsp_valid), .mem_rsp_ready(w_mem_rsp_ready),
    .mem_rsp_rdata(w_mem_rsp_rdata), .mem_rsp_err(w_mem_rsp_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept.
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, wd,
                       input bit has_req, input logic [31:0] q_wd, input logic [3:0] q_strb,
                       input int stall, input logic [31:0] rd, input logic rerr, input bit hold,
                       input logic [31:0] e_rd, input logic e_err, input int lat,
                       input int ostall);
    req_t r;
    exp_t e;
    int   n;
    r = '{addr: a & 32'hffff_fffc, wdata: q_wd, wen: st, wstrb: q_strb, stall: stall,
          rdata: rd, err: rerr, hold: hold};
    e = '{rdata: {32'h0, e_rd}, err: e_err, lat: lat, ostall: ostall};
    if (has_req) req_q.push_back(r);
    if (!hold) exp_q.push_back(e);
    in_valid = 1'b1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, required 1", n);
    end
    last_accept = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic issue64(input logic st, input logic [2:0] f3, input logic [63:0] a, wd, rd,
                         input bit has_req, input logic [63:0] q_addr, q_wd,
                         input logic [7:0] q_strb, input logic [63:0] e_rd, input logic e_err);
    int n;
    rd64 = rd;
    exp64_q.push_back('{rdata: e_rd, err: e_err, lat: 0, ostall: 0});
    w_in_valid = 1'b1; w_in_is_store = st; w_in_funct3 = f3; w_in_addr = a; w_in_wdata = wd;
    n = 0;
    while (!w_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    w_in_valid = 1'b0;
    chk("req64_valid", w_mem_req_valid, has_req);
    if (has_req) begin
      chk("req64_addr", w_mem_req_addr, q_addr);
      chk("req64_wen", w_mem_req_wen, st);
      chk("req64_wdata", w_mem_req_wdata, q_wd);
      chk("req64_wstrb", w_mem_req_wstrb, q_strb);
    end
    n = 0;
    while (exp64_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out64_pending", exp64_q.size(), 0);
  endtask

  // Bus model for the 32-bit instance: checks requests, stalls, then answers.
  initial begin : bfm
    req_t        cur;
    bit          busy, have_cur;
    int          left;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_strb;
    busy = 0; have_cur = 0; left = 0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    forever begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = force_rsp;
      mem_rsp_rdata = force_rsp ? 32'hcafe_f00d : 32'h0;
      mem_rsp_err   = 1'b0;
      if (rst_n) begin
        busy = 0; have_cur = 0;
      end else begin
        if (mem_rsp_ready && have_cur && !cur.hold) begin
          mem_rsp_valid = 1'b1; mem_rsp_rdata = cur.rdata; mem_rsp_err = cur.err;
          have_cur = 0;
        end
        if (mem_req_valid) begin
          if (!busy) begin
            busy = 1; left = 0;
            if (req_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_req: mem_req_valid with addr 0x%0h, none required",
                       mem_req_addr);
            end else begin
              cur = req_q.pop_front();
              left = cur.stall;
              chk("req_addr", mem_req_addr, cur.addr);
              chk("req_wen", mem_req_wen, cur.wen);
              chk("req_wdata", mem_req_wdata, cur.wdata);
              chk("req_wstrb", mem_req_wstrb, cur.wstrb);
              chk("req_latency", cyc - last_accept, 1);
              chk("in_ready_busy", in_ready, 0);
            end
            s_addr = mem_req_addr; s_wdata = mem_req_wdata; s_strb = mem_req_wstrb;
          end else begin
            chk("req_addr_stable", mem_req_addr, s_addr);
            chk("req_wdata_stable", mem_req_wdata, s_wdata);
            chk("req_wstrb_stable", mem_req_wstrb, s_strb);
          end
          if (left > 0) begin
            left--;
          end else begin
            mem_req_ready = 1'b1; busy = 0; have_cur = 1;
          end
        end
      end
    end
  end

  initial begin : mon
    exp_t        e;
    bit          busy;
    int          left;
    logic [31:0] s_rd;
    logic        s_err;
    busy = 0; left = 0; out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        busy = 0; out_ready = 1'b0;
      end else if (out_valid) begin
        if (!busy) begin
          busy = 1; left = 0;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_out: out_valid with rdata 0x%0h, no result required",
                     out_rdata);
          end else begin
            e = exp_q.pop_front();
            chk("out_rdata", out_rdata, e.rdata);
            chk("out_err", out_err, e.err);
            chk("out_latency", cyc - last_accept, e.lat);
            left = e.ostall;
          end
          s_rd = out_rdata; s_err = out_err;
        end else begin
          chk("out_rdata_stable", out_rdata, s_rd);
          chk("out_err_stable", out_err, s_err);
        end
        if (left > 0) begin
          out_ready = 1'b0; left--;
        end else begin
          out_ready = 1'b1; out_hs_cyc = cyc; busy = 0;
        end
      end else begin
        out_ready = 1'b0;
      end
    end
  end

  initial begin : mon64
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n && w_out_valid) begin
        if (exp64_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_out64: rdata 0x%0h, no result required", w_out_rdata);
        end else begin
          e = exp64_q.pop_front();
          chk("out64_rdata", w_out_rdata, e.rdata);
          chk("out64_err", w_out_err, e.err);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish within 20000 cycles");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst_n = 1'b1;
    in_valid = 1'b0; in_is_store = 1'b0; in_funct3 = '0; in_addr = '0; in_wdata = '0;
    w_in_valid = 1'b0; w_in_is_store = 1'b0; w_in_funct3 = '0; w_in_addr = '0;
    w_in_wdata = '0; rd64 = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_wen", mem_req_wen, 0);
    chk("rst_req_wstrb", mem_req_wstrb, 0);
    chk("rst_rsp_ready", mem_rsp_ready, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // LB sign-extended from the top byte lane
    issue(0, 3'b000, 32'h8000_0003, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h80ff_1234, 0, 0,
          32'hffff_ff80, 0, 3, 0);
    // SH into the upper half
    issue(1, 3'b001, 32'h8000_0002, 32'h0000_abcd, 1, 32'habcd_0000, 4'b1100, 0, 32'h0, 0, 0,
          32'h0, 0, 3, 0);
    // LHU with a 5-cycle request stall and a bus fault
    issue(0, 3'b101, 32'h8000_0000, 32'h0, 1, 32'h0, 4'b0000, 5, 32'h1234_5678, 1, 0,
          32'h0, 1, 8, 0);
`ifdef LSU_MISALIGN_CHK_EN
    issue(0, 3'b010, 32'h8000_0001, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0,
          32'h0, 1, 1, 0);
    issue(1, 3'b010, 32'h8000_0003, 32'haabb_ccdd, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0,
          32'h0, 1, 1, 0);
`else
    issue(0, 3'b010, 32'h8000_0001, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h1122_3344, 0, 0,
          32'h0011_2233, 0, 3, 0);
    issue(1, 3'b010, 32'h8000_0003, 32'haabb_ccdd, 1, 32'hdd00_0000, 4'b1000, 0, 32'h0, 0, 0,
          32'h0, 0, 3, 0);
`endif
    // LW with result back-pressure, then a request waiting behind it
    issue(0, 3'b010, 32'h8000_0004, 32'h0, 1, 32'h0, 4'b0000, 0, 32'hdead_beef, 0, 0,
          32'hdead_beef, 0, 3, 3);
    issue(0, 3'b100, 32'h8000_0005, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h0000_a500, 0, 0,
          32'h0000_00a5, 0, 3, 0);
    chk("accept_after_out_hs", last_accept, out_hs_cyc + 1);
    // Illegal encodings on XLEN=32: LD, store with funct3[2], funct3 111
    issue(0, 3'b011, 32'h8000_0000, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0);
    issue(1, 3'b100, 32'h8000_0000, 32'h55, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0);
    issue(0, 3'b111, 32'h8000_0000, 32'h0, 0, 32'h0, 4'b0000, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0);
    issue(1, 3'b010, 32'h8000_0008, 32'h1234_5678, 1, 32'h1234_5678, 4'b1111, 0, 32'h0, 0, 0,
          32'h0, 0, 3, 0);
    issue(0, 3'b001, 32'h8000_0002, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h8001_ffff, 0, 0,
          32'hffff_8001, 0, 3, 0);
    issue(1, 3'b000, 32'h8000_0001, 32'h0000_00ee, 1, 32'h0000_ee00, 4'b0010, 0, 32'h0, 0, 0,
          32'h0, 0, 3, 0);

    // Reset while waiting for a response; a late response must be ignored
    issue(0, 3'b010, 32'h8000_0010, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h0, 0, 1,
          32'h0, 0, 0, 0);
    n = 0;
    while (!mem_rsp_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reached_resp", mem_rsp_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_in_ready", in_ready, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_out_err", out_err, 0);
    chk("rst2_out_rdata", out_rdata, 0);
    chk("rst2_req_valid", mem_req_valid, 0);
    chk("rst2_rsp_ready", mem_rsp_ready, 0);
    rst_n = 1'b0;
    force_rsp = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("late_rsp_ignored", out_valid, 0);
    end
    force_rsp = 1'b0;
    issue(0, 3'b000, 32'h8000_0003, 32'h0, 1, 32'h0, 4'b0000, 0, 32'h80ff_1234, 0, 0,
          32'hffff_ff80, 0, 3, 0);

    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", exp_q.size() + req_q.size(), 0);

    // XLEN=64 instance
    issue64(0, 3'b110, 64'h4, 64'h0, 64'hf000_0000_0000_0000, 1, 64'h0, 64'h0, 8'h00,
            64'h0000_0000_f000_0000, 0);
    issue64(0, 3'b010, 64'h4, 64'h0, 64'hf000_0000_0000_0000, 1, 64'h0, 64'h0, 8'h00,
            64'hffff_ffff_f000_0000, 0);
    issue64(0, 3'b011, 64'h8, 64'h0, 64'h0123_4567_89ab_cdef, 1, 64'h8, 64'h0, 8'h00,
            64'h0123_4567_89ab_cdef, 0);
    issue64(0, 3'b000, 64'hf, 64'h0, 64'h8000_0000_0000_0000, 1, 64'h8, 64'h0, 8'h00,
            64'hffff_ffff_ffff_ff80, 0);
    issue64(1, 3'b010, 64'h14, 64'h0000_0000_dead_beef, 64'h0, 1, 64'h10,
            64'hdead_beef_0000_0000, 8'hf0, 64'h0, 0);
    issue64(1, 3'b011, 64'h18, 64'h1122_3344_5566_7788, 64'h0, 1, 64'h18,
            64'h1122_3344_5566_7788, 8'hff, 64'h0, 0);
    issue64(0, 3'b111, 64'h0, 64'h0, 64'h0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
